aes_encryption: RTL and testbench
=================================

AES_ENCRYPTION -- requirements
Module: aes_encryption

Interface
REQ-001 Parameters: none; AES-128 only.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 set_new_key  input  1  load key_in into the cipher-key register.
REQ-005 key_in  input  128  AES-128 cipher key.
REQ-006 start  input  1  begin encryption of plain_text.
REQ-007 plain_text  input  128  input block.
REQ-008 cipher_text  output  128  registered output block.
REQ-009 ready_enc  output  1  high when idle and able to accept start/set_new_key.
REQ-010 done_enc  output  1  one-cycle pulse when cipher_text is updated.

Function
REQ-011 Byte order shall be FIPS-197: bits [127:120] are byte 0; bytes fill state column-major (byte 4c+r is row r, column c); this applies to key, plaintext and ciphertext.
REQ-012 Key load: at an edge with set_new_key=1 and ready_enc=1, the key register shall take key_in; set_new_key while busy shall be ignored.
REQ-013 Start: at an edge with start=1 and ready_enc=1, state shall take plain_text XOR key register (round 0), the round counter shall be set to 1, and ready_enc shall go low.
REQ-014 When set_new_key and start are both high at the same accepted edge, key_in shall be used for round 0 and latched for the rest of that encryption.
REQ-015 Start while ready_enc=0 shall be ignored; no queuing.
REQ-016 Rounds: one round per cycle on the next 10 edges (E1..E10 after the start edge E0).
REQ-017 Rounds 1-9 shall apply SubBytes, ShiftRows, MixColumns and AddRoundKey.
REQ-018 Round 10 shall omit MixColumns.
REQ-019 Round keys shall be generated on the fly, one per round, from the previous round key with the standard AES-128 schedule (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1B,36).
REQ-020 The key register itself shall remain unchanged during rounds.
REQ-021 At E10, cipher_text shall take the round-10 result, done_enc shall be 1 for exactly one cycle, and ready_enc shall return to 1.
REQ-022 Latency from start edge to done_enc high shall be 10 cycles; back-to-back start is allowed in the cycle done_enc is high.
REQ-023 cipher_text shall hold its value until the next completed encryption; it is not cleared on start or when done_enc falls.
REQ-024 The S-box shall be the FIPS-197 forward S-box (table or GF(2^8) inverse plus affine transform; implementer's choice).
REQ-025 MixColumns shall use GF(2^8) with polynomial 0x11B.
REQ-026 Controller states shall be IDLE (ready_enc=1) and BUSY (round 1..10). IDLE->BUSY on accepted start; BUSY->IDLE at round 10.

Reset
REQ-027 While reset=1 at an edge: cipher_text=0, done_enc=0, ready_enc=1, key register=0, round counter=0, state=0.
REQ-028 Reset mid-operation shall abort the encryption with no done_enc pulse.
REQ-029 Reset shall take priority over start and set_new_key in the same cycle.

Verification
REQ-030 Key load 2b7e151628aed2a6abf7158809cf4f3c, then start with plain_text 3243f6a8885a308d313198a2e0370734 -> done_enc 10 cycles later, cipher_text 3925841d02dc09fbdc118597196a0b32.
REQ-031 Same key, no reload, plain_text 00112233445566778899aabbccddeeff -> cipher_text 8df4e9aac5c7573a27d8d055d6e4d64b.
REQ-032 Reload key 000102030405060708090a0b0c0d0e0f, plain_text 00112233445566778899aabbccddeeff -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a; value still held 1 cycle after done_enc falls.
REQ-033 Pulse start and set_new_key (with a different key) during BUSY -> both ignored: result and timing unchanged, next encryption uses old key.
REQ-034 Assert reset at round 5 -> no done_enc pulse, cipher_text=0, ready_enc=1; a fresh start afterwards gives a correct result.
REQ-035 Start issued in the cycle done_enc is high -> second result 10 cycles later; done_enc pulses exactly once per encryption.

Source files
------------

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// ready_enc is high in IDLE; done_enc pulses for one cycle when cipher_text updates.
module aes_encryption (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_new_key,
  input  logic [127:0] key_in,
  input  logic         start,
  input  logic [127:0] plain_text,
  output logic [127:0] cipher_text,
  output logic         ready_enc,
  output logic         done_enc
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ctrl_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  ctrl_t        ctrl;
  logic [3:0]   rnd;
  logic [127:0] key_reg;
  logic [127:0] round_key;
  logic [127:0] state_q;
  logic [127:0] next_key;
  logic [127:0] sub_shift;
  logic [127:0] mixed;
  logic [127:0] round_out;
  logic [127:0] key0;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign key0 = set_new_key ? key_in : key_reg;

  // Next round key derived from the current one; rnd selects Rcon.
  always_comb begin
    logic [31:0] temp;
    temp = {sbox(round_key[23:16]), sbox(round_key[15:8]),
            sbox(round_key[7:0]), sbox(round_key[31:24])} ^ {rcon(rnd), 24'h0};
    next_key[127:96] = round_key[127:96] ^ temp;
    next_key[95:64]  = round_key[95:64] ^ next_key[127:96];
    next_key[63:32]  = round_key[63:32] ^ next_key[95:64];
    next_key[31:0]   = round_key[31:0] ^ next_key[63:32];
  end

  // SubBytes + ShiftRows: byte (r,c) takes byte (r,(c+r) mod 4).
  always_comb begin
    sub_shift = '0;
    for (int i = 0; i < 16; i++) begin
      int r, c, src;
      r = i % 4;
      c = i / 4;
      src = 4 * ((c + r) % 4) + r;
      sub_shift[127-8*i -: 8] = sbox(state_q[127-8*src -: 8]);
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sub_shift[127-32*c -: 8];
      a1 = sub_shift[119-32*c -: 8];
      a2 = sub_shift[111-32*c -: 8];
      a3 = sub_shift[103-32*c -: 8];
      mixed[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mixed[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mixed[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mixed[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign round_out = ((rnd == 4'd10) ? sub_shift : mixed) ^ next_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl        <= IDLE;
      rnd         <= 4'd0;
      key_reg     <= '0;
      round_key   <= '0;
      state_q     <= '0;
      cipher_text <= '0;
      ready_enc   <= 1'b1;
      done_enc    <= 1'b0;
    end else begin
      done_enc <= 1'b0;
      case (ctrl)
        IDLE: begin
          if (set_new_key) key_reg <= key_in;
          if (start) begin
            state_q   <= plain_text ^ key0;
            round_key <= key0;
            rnd       <= 4'd1;
            ctrl      <= BUSY;
            ready_enc <= 1'b0;
          end
        end
        BUSY: begin
          state_q   <= round_out;
          round_key <= next_key;
          rnd       <= rnd + 4'd1;
          if (rnd == 4'd10) begin
            cipher_text <= round_out;
            done_enc    <= 1'b1;
            ready_enc   <= 1'b1;
            ctrl        <= IDLE;
            rnd         <= 4'd0;
          end
        end
        default: ctrl <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encryption.sv
// Bench for aes_encryption: drivers push expected ciphertext/done cycle into queues,
// a negedge monitor pops and compares whenever done_enc is seen.
module tb_aes_encryption;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h8df4e9aac5c7573a27d8d055d6e4d64b;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         set_new_key = 1'b0;
  logic [127:0] key_in = '0;
  logic         start = 1'b0;
  logic [127:0] plain_text = '0;
  logic [127:0] cipher_text;
  logic         ready_enc;
  logic         done_enc;

  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] exp_q[$];
  int           cyc_q[$];
  logic [127:0] model_key = '0;
  logic [7:0]   sbox_m[256];

  aes_encryption dut (
    .clk(clk), .reset(reset), .set_new_key(set_new_key), .key_in(key_in),
    .start(start), .plain_text(plain_text), .cipher_text(cipher_text),
    .ready_enc(ready_enc), .done_enc(done_enc)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_m[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < 10)
            s[r][c] = gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done_enc pulse must match the oldest expected result and cycle.
  always @(negedge clk) begin
    if (!reset && done_enc) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 128'(cyc), 128'hffffffff);
      end else begin
        check("cipher", cipher_text, exp_q.pop_front());
        check("latency", 128'(cyc), 128'(cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic wait_ready();
    int n = 0;
    while (!ready_enc && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_enc) check("ready_timeout", 128'(ready_enc), 128'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_enc && n < 40);
    if (!done_enc) check("done_timeout", 128'(done_enc), 128'd1);
  endtask

  task automatic load_key(input logic [127:0] k);
    wait_ready();
    set_new_key = 1'b1;
    key_in = k;
    @(posedge clk);
    #1 model_key = k;
    @(negedge clk);
    set_new_key = 1'b0;
  endtask

  task automatic issue(input logic load, input logic [127:0] k, input logic [127:0] p);
    wait_ready();
    set_new_key = load;
    key_in = k;
    plain_text = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (load) model_key = k;
    exp_q.push_back(ref_encrypt(model_key, p));
    cyc_q.push_back(cyc + 10);
    @(negedge clk);
    start = 1'b0;
    set_new_key = 1'b0;
  endtask

  task automatic wait_done_check(input string name, input logic [127:0] v);
    wait_done();
    check(name, cipher_text, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    build_sbox();
    // Reset wins over start/set_new_key asserted at the same edges
    start = 1'b1;
    set_new_key = 1'b1;
    key_in = K1;
    plain_text = P1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cipher", cipher_text, '0);
    check("rst_ready", 128'(ready_enc), 128'd1);
    check("rst_done", 128'(done_enc), 128'd0);
    start = 1'b0;
    set_new_key = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(ready_enc), 128'd1);

    // Key register cleared by reset: encrypt with the all-zero key
    issue(1'b0, '0, P2);
    wait_done();

    // Known vectors
    load_key(K1);
    issue(1'b0, '0, P1);
    wait_done_check("fips_c1", C1);
    issue(1'b0, '0, P2);
    wait_done_check("fips_c2", C2);
    issue(1'b1, K3, P2);
    wait_done_check("fips_c3", C3);
    @(negedge clk);
    check("done_one_cycle", 128'(done_enc), 128'd0);
    @(negedge clk);
    check("cipher_hold", cipher_text, C3);

    // Start and key load while busy are ignored
    issue(1'b0, '0, P1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    set_new_key = 1'b1;
    key_in = K1;
    plain_text = P2;
    @(negedge clk);
    check("busy_ready", 128'(ready_enc), 128'd0);
    start = 1'b0;
    set_new_key = 1'b0;
    wait_done();
    issue(1'b0, '0, P2);
    wait_done_check("old_key_kept", C3);

    // Reset during round 5 aborts without a done pulse
    issue(1'b0, '0, P1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cipher", cipher_text, '0);
    check("abort_ready", 128'(ready_enc), 128'd1);
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    model_key = '0;
    repeat (12) @(negedge clk);
    issue(1'b1, K1, P1);
    wait_done_check("after_abort", C1);

    // Back-to-back: start in the done cycle
    issue(1'b0, '0, P2);
    wait_done_check("b2b_first", C2);
    issue(1'b0, '0, P1);
    wait_done_check("b2b_second", C1);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      logic [127:0] k, p;
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) load_key({$urandom, $urandom, $urandom, $urandom});
      issue(1'($urandom_range(0, 1)), k, p);
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    // Drain outstanding results
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
